// File: rtl/sipo_receiver_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
//   state_e    : receiver FSM states
//   DATA_W_DEF : default payload width in bits
//   CNT_W_DEF  : bit-counter width for the default payload width
package sipo_receiver_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = $clog2(DATA_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } state_e;

endpackage

// File: rtl/sipo_receiver.sv
// Serial-to-parallel frame receiver with a one-entry holding register.
// Line format: idle high, start bit 0, DATA_W bits LSB first, stop bit 1,
// one bit per clock.
// Ports:
//   CLK       : clock, rising edge
//   RST       : synchronous active-low reset
//   Enable    : receive enable; low returns the receiver to IDLE
//   D_In      : serial line
//   Ready     : consumer accepts D_Out when high together with Valid
//   D_Out     : received byte, stable while Valid is high
//   Valid     : byte available, held until accepted
//   Frame_Err : one-cycle pulse when the stop bit is sampled low
//   Overrun   : sticky, a completed byte was dropped because D_Out was full
//   Busy      : receiver is not in IDLE
module sipo_receiver
  import sipo_receiver_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Enable,
  input  logic              D_In,
  input  logic              Ready,
  output logic [DATA_W-1:0] D_Out,
  output logic              Valid,
  output logic              Frame_Err,
  output logic              Overrun,
  output logic              Busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                ferr_q, ferr_d;
  logic                ovr_q, ovr_d;
  logic                busy_q, busy_d;
  logic                commit_c;

  // State and datapath registers; reset wins over every transition.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, shift/count, and holding-register handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = ovr_q;
    commit_c = 1'b0;

    // Ready only matters while a byte is being presented.
    if (valid_q && Ready) begin
      valid_d = 1'b0;
    end

    if (!Enable) begin
      // Abandon any partial frame; the holding register is untouched.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!D_In) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          // Right shift so the first bit received ends up in bit 0.
          shift_d = {D_In, shift_q[DATA_W-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = STOP;
          end
        end
        STOP: begin
          if (D_In) begin
            commit_c = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
        BREAK: begin
          if (D_In) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A commit lands only if the holding register is empty or draining now.
    if (commit_c) begin
      if (!valid_q || Ready) begin
        dout_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign D_Out     = dout_q;
  assign Valid     = valid_q;
  assign Frame_Err = ferr_q;
  assign Overrun   = ovr_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver: stimulus pushes expected bytes into a
// queue, a negedge monitor pops and compares on each new Valid presentation.
module tb_sipo_receiver;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Enable = 1'b0;
  logic       D_In = 1'b1;
  logic       Ready = 1'b0;
  logic [7:0] D_Out;
  logic       Valid;
  logic       Frame_Err;
  logic       Overrun;
  logic       Busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  longint     pres_t[$];
  bit         presented = 1'b0;
  int         ferr_seen = 0;
  int         valid_cycles = 0;

  sipo_receiver #(.DATA_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Enable   (Enable),
    .D_In     (D_In),
    .Ready    (Ready),
    .D_Out    (D_Out),
    .Valid    (Valid),
    .Frame_Err(Frame_Err),
    .Overrun  (Overrun),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare each newly presented byte against the queue.
  always @(negedge CLK) begin
    logic [7:0] e;
    if (Valid) valid_cycles++;
    if (Frame_Err) ferr_seen++;
    if (Valid && !presented) begin
      pres_t.push_back($time);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {24'd0, D_Out}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("dout_scoreboard", {24'd0, D_Out}, {24'd0, e});
      end
      presented = 1'b1;
    end
    // A transfer happens on the coming edge; any byte after it is new.
    if (!Valid || Ready) presented = 1'b0;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_bit(input logic b);
    D_In = b;
    tick();
  endtask

  task automatic send_data(input logic [7:0] v);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stop);
    send_data(v);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    D_In = 1'b1;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    D_In = 1'b1;
    tick();
    tick();
    RST = 1'b1;
  endtask

  initial begin
    logic [7:0] v;

    // Reset state
    Enable = 1'b0;
    do_reset();
    chk("rst_dout", {24'd0, D_Out}, 32'h0);
    chk("rst_valid", {31'd0, Valid}, 32'h0);
    chk("rst_ferr", {31'd0, Frame_Err}, 32'h0);
    chk("rst_overrun", {31'd0, Overrun}, 32'h0);
    chk("rst_busy", {31'd0, Busy}, 32'h0);

    // 0xA5 held with Ready=0, then accepted
    Enable = 1'b1;
    Ready  = 1'b0;
    idle(2);
    exp_q.push_back(8'hA5);
    v = 8'hA5;
    send_bit(1'b0);
    chk("a5_busy_after_start", {31'd0, Busy}, 32'h1);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    chk("a5_valid_before_stop", {31'd0, Valid}, 32'h0);
    send_bit(1'b1);
    chk("a5_valid_after_stop", {31'd0, Valid}, 32'h1);
    chk("a5_dout", {24'd0, D_Out}, 32'hA5);
    idle(3);
    chk("a5_valid_held", {31'd0, Valid}, 32'h1);
    chk("a5_dout_held", {24'd0, D_Out}, 32'hA5);
    Ready = 1'b1;
    tick();
    chk("a5_valid_dropped", {31'd0, Valid}, 32'h0);

    // 0x3C then 0xC3 back-to-back, Ready=1
    idle(2);
    pres_t.delete();
    valid_cycles = 0;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    idle(3);
    chk("b2b_valid_cycles", valid_cycles, 32'd2);
    if (pres_t.size() == 2) chk("b2b_spacing_ns", 32'(pres_t[1] - pres_t[0]), 32'd100);
    else chk("b2b_presentations", pres_t.size(), 32'd2);
    chk("b2b_overrun", {31'd0, Overrun}, 32'h0);

    // 0x55 with bad stop bit, BREAK, then 0x12
    ferr_seen = 0;
    send_frame(8'h55, 1'b0);
    chk("ferr_pulse", {31'd0, Frame_Err}, 32'h1);
    chk("ferr_no_valid", {31'd0, Valid}, 32'h0);
    send_bit(1'b0);
    chk("ferr_one_cycle", {31'd0, Frame_Err}, 32'h0);
    send_bit(1'b0);
    send_bit(1'b0);
    chk("break_busy", {31'd0, Busy}, 32'h1);
    send_bit(1'b1);
    chk("break_exit_idle", {31'd0, Busy}, 32'h0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    idle(2);
    chk("ferr_count", ferr_seen, 32'd1);

    // Overrun: 0x11 held, 0x22 dropped
    do_reset();
    Ready = 1'b0;
    idle(1);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(1);
    chk("ovr_dout_kept", {24'd0, D_Out}, 32'h11);
    chk("ovr_set", {31'd0, Overrun}, 32'h1);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    idle(2);
    chk("ovr_sticky", {31'd0, Overrun}, 32'h1);

    // Commit coinciding with accept: 0x22 replaces 0x11, no overrun
    do_reset();
    chk("ovr_cleared_by_reset", {31'd0, Overrun}, 32'h0);
    idle(1);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(1);
    exp_q.push_back(8'h22);
    send_data(8'h22);
    Ready = 1'b1;
    send_bit(1'b1);
    chk("swap_dout", {24'd0, D_Out}, 32'h22);
    chk("swap_valid", {31'd0, Valid}, 32'h1);
    chk("swap_overrun", {31'd0, Overrun}, 32'h0);
    idle(2);

    // Enable dropped mid-frame of 0x7E, prior byte 0x44 unaffected, then 0x81
    Ready = 1'b0;
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b1);
    idle(1);
    v = 8'h7E;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(v[i]);
    Enable = 1'b0;
    for (int i = 4; i < 8; i++) send_bit(v[i]);
    chk("en_low_busy", {31'd0, Busy}, 32'h0);
    send_bit(1'b1);
    send_bit(1'b0);
    Enable = 1'b1;
    idle(2);
    chk("en_valid_kept", {31'd0, Valid}, 32'h1);
    chk("en_dout_kept", {24'd0, D_Out}, 32'h44);
    chk("en_no_overrun", {31'd0, Overrun}, 32'h0);
    Ready = 1'b1;
    tick();
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(2);

    // Reset mid-frame with 0x99 held, then 0x5A
    Ready = 1'b0;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1);
    idle(1);
    chk("pre_rst_dout", {24'd0, D_Out}, 32'h99);
    v = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(v[i]);
    RST = 1'b0;
    send_bit(v[3]);
    chk("midrst_dout", {24'd0, D_Out}, 32'h0);
    chk("midrst_valid", {31'd0, Valid}, 32'h0);
    chk("midrst_busy", {31'd0, Busy}, 32'h0);
    chk("midrst_overrun", {31'd0, Overrun}, 32'h0);
    chk("midrst_ferr", {31'd0, Frame_Err}, 32'h0);
    RST = 1'b1;
    idle(1);
    Ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame.
REQ-002 CLK  input  1  clock; all logic on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-low.
REQ-004 Enable  input  1  receive enable; low forces receiver to IDLE.
REQ-005 D_In  input  1  serial line; idle high, start bit 0, DATA_W bits LSB first, stop bit 1, one bit per CLK.
REQ-006 Ready  input  1  consumer accepts the held byte when high with Valid.
REQ-007 D_Out  output  DATA_W  received byte, registered, stable while Valid high.
REQ-008 Valid  output  1  byte available; held until accepted.
REQ-009 Frame_Err  output  1  one-cycle pulse: stop bit sampled 0.
REQ-010 Overrun  output  1  sticky: a completed byte was dropped because the holding register was full.
REQ-011 Busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have the states IDLE, DATA, STOP and BREAK.
REQ-013 IDLE: with Enable=1 and D_In=0 sampled, go to DATA, bit counter=0; otherwise stay.
REQ-014 DATA: each cycle, shift D_In into the shift register MSB (right shift) and increment the counter; after DATA_W bits, go to STOP, so the first received bit lands in bit 0.
REQ-015 Counter width SHALL be clog2(DATA_W+1); the counter SHALL never wrap within a frame.
REQ-016 STOP with D_In=1: commit the shift register to the holding register and go to IDLE.
REQ-017 STOP with D_In=0: pulse Frame_Err for one cycle, discard the byte, go to BREAK.
REQ-018 BREAK: stay until D_In=1 is sampled, then go to IDLE; no start detection in BREAK.
REQ-019 Latency: start bit sampled at cycle t, data at t+1..t+DATA_W, stop at t+DATA_W+1; Valid and D_Out updated at t+DATA_W+2 (t+10 for DATA_W=8).
REQ-020 Back-to-back frames: a start bit on the cycle after the stop bit SHALL be detected with no idle gap required.
REQ-021 Handshake: transfer occurs when Valid=1 and Ready=1 on the same edge; Valid then drops next cycle unless a commit coincides.
REQ-022 Commit when Valid=0, or Valid=1 with Ready=1 the same cycle: load D_Out, set Valid=1, no overrun.
REQ-023 Commit when Valid=1 and Ready=0: keep the old D_Out, drop the new byte, set Overrun=1.
REQ-024 Overrun SHALL clear only on reset.
REQ-025 Enable=0 in any state: next state IDLE and partial frame discarded; Valid, D_Out and Overrun SHALL be unaffected.
REQ-026 Ready SHALL be ignored while Valid=0.

Reset
REQ-027 On RST=0 at a CLK edge, within one cycle and regardless of state: state=IDLE, counter=0, shift register=0, D_Out=0, Valid=0, Frame_Err=0, Overrun=0, Busy=0.
REQ-028 Reset SHALL take priority over Enable and over all FSM transitions; a frame in progress is discarded.

Structure
REQ-029 Package sipo_receiver_pkg SHALL hold the state enum (IDLE, DATA, STOP, BREAK), the DATA_W default, and the counter-width constant.
REQ-030 The block SHALL be a single module with no sub-module; FSM, counter, shift register and holding register are local.

Verification
REQ-031 0xA5 frame (line 0,1,0,1,0,0,1,0,1,1), Ready=0 -> D_Out=0xA5 and Valid=1 at t+10, held until Ready=1; Valid=0 one cycle after accept.
REQ-032 0x3C then 0xC3 back-to-back, no gap, Ready=1 -> two one-cycle Valid pulses 10 cycles apart carrying 0x3C then 0xC3; Overrun=0.
REQ-033 0x55 frame with stop bit 0, line held 0 three more cycles, then 1, then 0x12 frame -> Frame_Err pulse at t+10, no Valid for 0x55, BREAK until the line is high, then 0x12 received.
REQ-034 0x11 held with Ready=0, then 0x22 frame completes -> D_Out stays 0x11, Overrun=1; a second test with Ready=1 on the commit cycle -> D_Out=0x22, Overrun=0.
REQ-035 Enable dropped at data bit 4 of 0x7E, then restored with a fresh 0x81 frame -> no output for 0x7E; 0x81 received; prior Valid/D_Out unchanged.
REQ-036 RST=0 at data bit 3 with Valid=1, D_Out=0x99 -> all outputs 0 next cycle; a following 0x5A frame is received correctly.
